// File: rtl/flag_pkg.sv
// flag_pkg: shared constants, FSM state type and write-enable decode for the
// Z/V/N flag sequencer.
package flag_pkg;

  localparam int unsigned FLAG_W = 3;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned CC_W   = 3;

  // Flag bit positions in flags_q / flag_wen / flag_din
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  // Flag-writing opcodes
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OPC_W-1:0] OP_XOR = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SLL = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SRA = 4'b0101;
  localparam logic [OPC_W-1:0] OP_ROR = 4'b0110;

  // Branch condition codes
  localparam logic [CC_W-1:0] CC_NE     = 3'b000;
  localparam logic [CC_W-1:0] CC_EQ     = 3'b001;
  localparam logic [CC_W-1:0] CC_GT     = 3'b010;
  localparam logic [CC_W-1:0] CC_LT     = 3'b011;
  localparam logic [CC_W-1:0] CC_GE     = 3'b100;
  localparam logic [CC_W-1:0] CC_LE     = 3'b101;
  localparam logic [CC_W-1:0] CC_OV     = 3'b110;
  localparam logic [CC_W-1:0] CC_UNCOND = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_state_e;

  // Per-bit flag write enables implied by an opcode (before valid gating)
  function automatic logic [FLAG_W-1:0] wen_decode(input logic [OPC_W-1:0] op);
    logic [FLAG_W-1:0] wen;
    wen = '0;
    case (op)
      OP_ADD, OP_SUB:                 wen = '1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: wen[FLAG_Z] = 1'b1;
      default:                        wen = '0;
    endcase
    return wen;
  endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// flag_ctrl_if: ID/EX-side inputs and flag-register-side outputs of flag_ctrl.
interface flag_ctrl_if
  import flag_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
);

  logic                   ex_valid;
  logic                   ex_flush;
  logic [OPC_W-1:0]       ex_opcode;
  logic                   ex_z;
  logic                   ex_v;
  logic                   ex_n;
  logic                   id_valid;
  logic                   id_is_branch;
  logic [CC_W-1:0]        id_cond;
  logic [FLAG_W-1:0]      flags_q;
  logic [FLAG_W-1:0]      flag_wen;
  logic [FLAG_W-1:0]      flag_din;
  logic                   stall;
  logic                   br_valid;
  logic                   br_taken;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Pipeline side driving the sequencer
  modport master (
    output ex_valid, ex_flush, ex_opcode, ex_z, ex_v, ex_n,
    output id_valid, id_is_branch, id_cond, flags_q,
    input  flag_wen, flag_din, stall, br_valid, br_taken, stall_cnt
  );

  // Sequencer side
  modport slave (
    input  ex_valid, ex_flush, ex_opcode, ex_z, ex_v, ex_n,
    input  id_valid, id_is_branch, id_cond, flags_q,
    output flag_wen, flag_din, stall, br_valid, br_taken, stall_cnt
  );

endinterface

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: combinational branch-condition evaluation on Z/V/N flags.
module flag_cond_eval
  import flag_pkg::*;
(
  input  logic [CC_W-1:0]   cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              taken
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  // Condition code decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:     taken = ~z;
      CC_EQ:     taken = z;
      CC_GT:     taken = ~z & ~n;
      CC_LT:     taken = n;
      CC_GE:     taken = z | ~n;
      CC_LE:     taken = z | n;
      CC_OV:     taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: flag write-enable sequencer and branch-condition scheduler.
// Optional feature macro FLAG_FWD_EN: forward EX flag results into branch
// evaluation instead of stalling on a flag hazard.
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  flag_ctrl_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_HOLD = 1'(HOLD);

  logic [0:0]             state_q;
  logic [0:0]             state_d;
  logic [FLAG_W-1:0]      wen;
  logic [FLAG_W-1:0]      din;
  logic [FLAG_W-1:0]      eff_flags;
  logic                   cond_taken;
  logic                   stall;
  logic                   br_valid;
  logic                   br_taken;
  logic [STALL_CNT_W-1:0] cnt_q;

  // Flag write decode; flush and reset suppress every write
  always_comb begin
    wen = '0;
    din = '0;
    if (!rst) begin
      din[FLAG_Z] = bus.ex_z;
      din[FLAG_V] = bus.ex_v;
      din[FLAG_N] = bus.ex_n;
      if (bus.ex_valid && !bus.ex_flush) begin
        wen = wen_decode(bus.ex_opcode);
      end
    end
  end

`ifdef FLAG_FWD_EN
  // Bits being written this cycle come from EX, the rest from the register
  assign eff_flags = (wen & din) | (~wen & bus.flags_q);
`else
  assign eff_flags = bus.flags_q;
`endif

  flag_cond_eval u_cond (
    .cond  (bus.id_cond),
    .flags (eff_flags),
    .taken (cond_taken)
  );

  // Next-state and branch/stall outputs
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    br_valid = 1'b0;
    br_taken = 1'b0;
    if (!rst) begin
      if (bus.ex_flush) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_HOLD: begin
            // Flags now hold the committed write; resolve the held branch
            br_valid = 1'b1;
            br_taken = cond_taken;
            state_d  = S_IDLE;
          end
          default: begin
            if (bus.id_valid && bus.id_is_branch) begin
`ifdef FLAG_FWD_EN
              br_valid = 1'b1;
              br_taken = cond_taken;
`else
              if (|wen) begin
                stall   = 1'b1;
                state_d = S_HOLD;
              end else begin
                br_valid = 1'b1;
                br_taken = cond_taken;
              end
`endif
            end
          end
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.flag_wen  = wen;
  assign bus.flag_din  = din;
  assign bus.stall     = stall;
  assign bus.br_valid  = br_valid;
  assign bus.br_taken  = br_taken;
  assign bus.stall_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: directed vectors with a scoreboard queue for flag_ctrl.
// A second instance with a 4-bit counter sees the same stimulus so that
// counter saturation can be reached in a short run.
module tb_flag_ctrl;
  import flag_pkg::*;

  typedef struct {
    string      nm;
    logic [2:0] wen;
    logic [2:0] din;
    logic [2:0] dmask;
    logic       stall;
    logic       brv;
    logic       brt;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  logic clk;
  logic rst;

  exp_t        q[$];
  int          errors;
  int          checks;
  logic [15:0] exp_cnt;
  bit          stim_done;

  flag_ctrl_if #(.STALL_CNT_W(16)) bus ();
  flag_ctrl_if #(.STALL_CNT_W(4))  bus_s ();

  flag_ctrl #(.STALL_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flag_ctrl #(.STALL_CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.ex_valid     = bus.ex_valid;
  assign bus_s.ex_flush     = bus.ex_flush;
  assign bus_s.ex_opcode    = bus.ex_opcode;
  assign bus_s.ex_z         = bus.ex_z;
  assign bus_s.ex_v         = bus.ex_v;
  assign bus_s.ex_n         = bus.ex_n;
  assign bus_s.id_valid     = bus.id_valid;
  assign bus_s.id_is_branch = bus.id_is_branch;
  assign bus_s.id_cond      = bus.id_cond;
  assign bus_s.flags_q      = bus.flags_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue what the outputs must be
  task automatic drive(input string nm, input logic r, input logic fl,
                       input logic v, input logic [3:0] op,
                       input logic z, input logic ov, input logic n,
                       input logic idv, input logic isb, input logic [2:0] cc,
                       input logic [2:0] fq, input logic [2:0] e_wen,
                       input logic e_stall, input logic e_brv, input logic e_brt);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.ex_flush     = fl;
    bus.ex_valid     = v;
    bus.ex_opcode    = op;
    bus.ex_z         = z;
    bus.ex_v         = ov;
    bus.ex_n         = n;
    bus.id_valid     = idv;
    bus.id_is_branch = isb;
    bus.id_cond      = cc;
    bus.flags_q      = fq;
    e.nm    = nm;
    e.wen   = e_wen;
    e.din   = r ? 3'b000 : {n, ov, z};
    e.dmask = r ? 3'b111 : e_wen;
    e.stall = e_stall;
    e.brv   = e_brv;
    e.brt   = e_brt;
    e.cnt   = r ? 16'd0 : exp_cnt;
    e.cnt_s = r ? 4'd0 : ((exp_cnt > 16'd15) ? 4'd15 : exp_cnt[3:0]);
    q.push_back(e);
    if (r) exp_cnt = 16'd0;
    else if (e_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic chk(input string nm, input string f, input logic [15:0] act,
                     input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s.%s got=%0h expected=%0h", nm, f, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle and checked against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "flag_wen",  16'(bus.flag_wen), 16'(e.wen));
        chk(e.nm, "flag_din",  16'(bus.flag_din & e.dmask), 16'(e.din & e.dmask));
        chk(e.nm, "stall",     16'(bus.stall), 16'(e.stall));
        chk(e.nm, "br_valid",  16'(bus.br_valid), 16'(e.brv));
        chk(e.nm, "br_taken",  16'(bus.br_taken & e.brv), 16'(e.brt));
        chk(e.nm, "stall_cnt", bus.stall_cnt, e.cnt);
        chk(e.nm, "stall_cnt_w4", 16'(bus_s.stall_cnt), 16'(e.cnt_s));
      end
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    exp_cnt   = 16'd0;
    stim_done = 1'b0;
    rst              = 1'b1;
    bus.ex_valid     = 1'b0;
    bus.ex_flush     = 1'b0;
    bus.ex_opcode    = 4'd0;
    bus.ex_z         = 1'b0;
    bus.ex_v         = 1'b0;
    bus.ex_n         = 1'b0;
    bus.id_valid     = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_cond      = 3'd0;
    bus.flags_q      = 3'd0;

    //     name              r  fl v  op      z  v  n  idv b  cc      fq      wen     st br tk
    drive("rst_force",       1, 0, 1, OP_ADD, 1, 1, 1, 1, 1, 3'b111, 3'b000, 3'b000, 0, 0, 0);
`ifndef FLAG_FWD_EN
    drive("add_flags",       0, 0, 1, OP_ADD, 1, 0, 1, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0);
    drive("sll_dec",         0, 0, 1, OP_SLL, 0, 1, 1, 0, 0, 3'b000, 3'b000, 3'b001, 0, 0, 0);
    drive("xor_hazard",      0, 0, 1, OP_XOR, 1, 0, 0, 1, 1, 3'b001, 3'b000, 3'b001, 1, 0, 0);
    drive("xor_resolve",     0, 0, 0, OP_XOR, 0, 0, 0, 1, 1, 3'b001, 3'b001, 3'b000, 0, 1, 1);
    drive("red_lt",          0, 0, 1, 4'b1000, 0, 0, 0, 1, 1, 3'b011, 3'b100, 3'b000, 0, 1, 1);
    drive("b2b_ne",          0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b000, 3'b001, 3'b000, 0, 1, 0);
    drive("b2b_gt",          0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b010, 3'b000, 3'b000, 0, 1, 1);
    drive("sub_hazard",      0, 0, 1, OP_SUB, 0, 1, 0, 1, 1, 3'b110, 3'b000, 3'b111, 1, 0, 0);
    drive("flush_hold",      0, 1, 1, OP_ADD, 1, 1, 1, 1, 1, 3'b110, 3'b010, 3'b000, 0, 0, 0);
    drive("le_hazard",       0, 0, 1, OP_ADD, 0, 0, 1, 1, 1, 3'b101, 3'b000, 3'b111, 1, 0, 0);
    drive("hold_exvalid",    0, 0, 1, OP_ADD, 1, 1, 0, 1, 1, 3'b101, 3'b100, 3'b111, 0, 1, 1);
    drive("flush_idle",      0, 1, 1, OP_XOR, 1, 0, 0, 1, 1, 3'b001, 3'b000, 3'b000, 0, 0, 0);
    drive("lt_clear",        0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b011, 3'b000, 3'b000, 0, 1, 0);
    drive("ge_nset",         0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b100, 3'b100, 3'b000, 0, 1, 0);
    drive("ge_clear",        0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b100, 3'b000, 3'b000, 0, 1, 1);
    drive("ov_set",          0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b110, 3'b010, 3'b000, 0, 1, 1);
    drive("eq_clear",        0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b001, 3'b000, 3'b000, 0, 1, 0);
    drive("id_invalid",      0, 0, 1, OP_XOR, 1, 0, 0, 0, 1, 3'b001, 3'b000, 3'b001, 0, 0, 0);
    drive("haz_pre_rst",     0, 0, 1, OP_SRA, 1, 0, 0, 1, 1, 3'b001, 3'b000, 3'b001, 1, 0, 0);
    drive("rst_in_hold",     1, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b001, 3'b001, 3'b000, 0, 0, 0);
    drive("post_rst_idle",   0, 0, 1, OP_ROR, 0, 0, 0, 1, 1, 3'b000, 3'b000, 3'b001, 1, 0, 0);
    drive("post_rst_res",    0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b000, 3'b000, 3'b000, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      drive("sat_hazard",    0, 0, 1, OP_ADD, 0, 0, 0, 1, 1, 3'b111, 3'b000, 3'b111, 1, 0, 0);
      drive("sat_resolve",   0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b111, 3'b000, 3'b000, 0, 1, 1);
    end
    drive("sat_rst",         1, 0, 1, OP_ADD, 1, 1, 1, 1, 1, 3'b111, 3'b000, 3'b000, 0, 0, 0);
    drive("after_rst",       0, 0, 0, OP_ADD, 0, 0, 0, 1, 1, 3'b111, 3'b000, 3'b000, 0, 1, 1);
`else
    drive("fwd_sub_ov",      0, 0, 1, OP_SUB, 0, 1, 0, 1, 1, 3'b110, 3'b000, 3'b111, 0, 1, 1);
    drive("fwd_xor_eq",      0, 0, 1, OP_XOR, 1, 0, 0, 1, 1, 3'b001, 3'b000, 3'b001, 0, 1, 1);
    drive("fwd_add_lt",      0, 0, 1, OP_ADD, 0, 0, 0, 1, 1, 3'b011, 3'b100, 3'b111, 0, 1, 0);
    drive("fwd_mixed_le",    0, 0, 1, OP_XOR, 0, 0, 0, 1, 1, 3'b101, 3'b100, 3'b001, 0, 1, 1);
    drive("fwd_flush",       0, 1, 1, OP_SUB, 0, 1, 0, 1, 1, 3'b110, 3'b000, 3'b000, 0, 0, 0);
    drive("fwd_rst",         1, 0, 1, OP_SUB, 0, 1, 0, 1, 1, 3'b110, 3'b000, 3'b000, 0, 0, 0);
`endif
    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report
  initial begin
    wait (stim_done);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
